// File: rtl/vadd_float_packer.sv
// Packs a narrow AXI4-Stream of float sums into wide words; tlast flushes a partial word.
// Optional build macro VADD_FLOAT_PACKER_ZERO_PAD_EN: zero data of unkept lanes and reset data registers.
module vadd_float_packer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_AXIS_TDATA_WIDTH = 512
) (
    input  logic                              ap_aclk,
    input  logic                              ap_areset,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic [31:0]                       word_count
);

    localparam int LP_S      = C_S_AXIS_TDATA_WIDTH;
    localparam int LP_M      = C_M_AXIS_TDATA_WIDTH;
    localparam int LP_SK     = LP_S / 8;
    localparam int LP_MK     = LP_M / 8;
    localparam int LP_RATIO  = LP_M / LP_S;
    localparam int LP_LANE_W = (LP_RATIO > 1) ? $clog2(LP_RATIO) : 1;
    localparam logic [LP_LANE_W-1:0] LP_LAST_LANE = LP_LANE_W'(LP_RATIO - 1);

    logic [LP_M-1:0]      r_accData;
    logic [LP_MK-1:0]     r_accKeep;
    logic                 r_accLast;
    logic                 r_accPending;
    logic [LP_LANE_W-1:0] r_lane;
    logic [LP_M-1:0]      r_outData;
    logic [LP_MK-1:0]     r_outKeep;
    logic                 r_outLast;
    logic                 r_outValid;
    logic [31:0]          r_wordCount;

    logic                 w_inHs;
    logic                 w_outFree;
    logic                 w_complete;
    logic [LP_M-1:0]      w_mergeData;
    logic [LP_MK-1:0]     w_mergeKeep;
    logic [LP_M-1:0]      w_accOutData;
    logic [LP_M-1:0]      w_beatOutData;

    assign s_axis_tready = ~r_accPending;
    assign w_inHs        = s_axis_tvalid & ~r_accPending;
    assign w_outFree     = ~r_outValid | m_axis_tready;
    assign w_complete    = w_inHs & ((r_lane == LP_LAST_LANE) | s_axis_tlast);

    assign m_axis_tvalid = r_outValid;
    assign m_axis_tdata  = r_outData;
    assign m_axis_tkeep  = r_outKeep;
    assign m_axis_tlast  = r_outLast;
    assign word_count    = r_wordCount;

    // Accumulator with the current beat dropped into its lane; keeps above that lane are zero.
    always_comb begin
        w_mergeData = r_accData;
        w_mergeKeep = '0;
        for (int i = 0; i < LP_RATIO; i++) begin
            if (LP_LANE_W'(i) == r_lane) begin
                w_mergeData[i*LP_S +: LP_S]  = s_axis_tdata;
                w_mergeKeep[i*LP_SK +: LP_SK] = s_axis_tkeep;
            end else if (LP_LANE_W'(i) < r_lane) begin
                w_mergeKeep[i*LP_SK +: LP_SK] = r_accKeep[i*LP_SK +: LP_SK];
            end
        end
    end

`ifdef VADD_FLOAT_PACKER_ZERO_PAD_EN
    always_comb begin
        w_accOutData  = r_accData;
        w_beatOutData = w_mergeData;
        for (int i = 0; i < LP_RATIO; i++) begin
            if (r_accKeep[i*LP_SK +: LP_SK] == '0) begin
                w_accOutData[i*LP_S +: LP_S] = '0;
            end
            if (w_mergeKeep[i*LP_SK +: LP_SK] == '0) begin
                w_beatOutData[i*LP_S +: LP_S] = '0;
            end
        end
    end
`else
    assign w_accOutData  = r_accData;
    assign w_beatOutData = w_mergeData;
`endif

    // A pending accumulator always drains first; input is stalled while it waits, so the branches are exclusive.
    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            r_lane       <= '0;
            r_accKeep    <= '0;
            r_accLast    <= 1'b0;
            r_accPending <= 1'b0;
            r_outKeep    <= '0;
            r_outLast    <= 1'b0;
            r_outValid   <= 1'b0;
            r_wordCount  <= '0;
        end else begin
            if (r_outValid & m_axis_tready) begin
                r_outValid  <= 1'b0;
                r_wordCount <= r_wordCount + 32'd1;
            end
            if (r_accPending & w_outFree) begin
                r_outKeep    <= r_accKeep;
                r_outLast    <= r_accLast;
                r_outValid   <= 1'b1;
                r_accPending <= 1'b0;
                r_lane       <= '0;
                r_accKeep    <= '0;
            end else if (w_complete & w_outFree) begin
                r_outKeep  <= w_mergeKeep;
                r_outLast  <= s_axis_tlast;
                r_outValid <= 1'b1;
                r_lane     <= '0;
                r_accKeep  <= '0;
            end else if (w_complete) begin
                r_accKeep    <= w_mergeKeep;
                r_accLast    <= s_axis_tlast;
                r_accPending <= 1'b1;
            end else if (w_inHs) begin
                r_accKeep <= w_mergeKeep;
                r_lane    <= r_lane + LP_LANE_W'(1);
            end
        end
    end

    // Data registers mirror the control branches above and are reset only in the zero-pad build.
    always_ff @(posedge ap_aclk) begin
`ifdef VADD_FLOAT_PACKER_ZERO_PAD_EN
        if (ap_areset) begin
            r_accData <= '0;
            r_outData <= '0;
        end else
`endif
        begin
            if (r_accPending & w_outFree) begin
                r_outData <= w_accOutData;
            end else if (w_complete & w_outFree) begin
                r_outData <= w_beatOutData;
            end else if (w_inHs) begin
                r_accData <= w_mergeData;
            end
        end
    end

endmodule

// File: tb/tb_vadd_float_packer.sv
// Scoreboard bench for vadd_float_packer: the driver pushes expected words, a negedge monitor pops and compares.
// Honours VADD_FLOAT_PACKER_ZERO_PAD_EN when the DUT is built with it.
module tb_vadd_float_packer;

    localparam int S     = 32;
    localparam int M     = 512;
    localparam int MK    = M / 8;
    localparam int RATIO = M / S;

    typedef struct {
        logic [M-1:0]  data;
        logic [MK-1:0] keep;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          ap_areset = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [S-1:0]  s_axis_tdata = '0;
    logic [3:0]    s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [M-1:0]  m_axis_tdata;
    logic [MK-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [31:0]   word_count;

    word_t         expQ[$];
    logic [M-1:0]  rxData[$];
    logic [MK-1:0] rxKeep[$];
    logic          rxLast[$];

    logic [M-1:0]  mData = '0;
    logic [MK-1:0] mKeep = '0;
    int            mLane = 0;
    int            wordsPushed = 0;
    int            notReadyWaits = 0;
    int            readyMode = 1;
    int            testsRun = 0;
    int            testsFailed = 0;

    vadd_float_packer #(
        .C_S_AXIS_TDATA_WIDTH(S),
        .C_M_AXIS_TDATA_WIDTH(M)
    ) dut (
        .ap_aclk       (clk),
        .ap_areset     (ap_areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    // Sole owner of m_axis_tready: 0 = held low, 1 = held high, 2 = random each cycle.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelAccept(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        mData[mLane*S +: S] = d;
        mKeep[mLane*4 +: 4] = k;
        if (mLane == RATIO - 1 || l) begin
            w.data = mData;
            w.keep = mKeep;
            w.last = l;
`ifdef VADD_FLOAT_PACKER_ZERO_PAD_EN
            for (int i = 0; i < RATIO; i++) begin
                if (w.keep[i*4 +: 4] == 4'h0) w.data[i*S +: S] = '0;
            end
`endif
            expQ.push_back(w);
            wordsPushed++;
            mData = '0;
            mKeep = '0;
            mLane = 0;
        end else begin
            mLane++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat's handshake edge.
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic l, input int idle);
        bit accepted = 1'b0;
        int waits = 0;
        repeat (idle) begin @(posedge clk); #1; end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        while (!accepted && waits <= 200) begin
            @(negedge clk);
            if (s_axis_tready) begin
                accepted = 1'b1;
            end else begin
                notReadyWaits++;
                waits++;
                @(posedge clk);
                #1;
            end
        end
        if (accepted) begin
            modelAccept(d, k, l);
            @(posedge clk);
            #1;
        end else begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL beat accept timeout: data 0x%0h never accepted", d);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic resetDut();
        ap_areset     = 1'b1;
        s_axis_tvalid = 1'b0;
        expQ.delete();
        rxData.delete();
        rxKeep.delete();
        rxLast.delete();
        mData = '0;
        mKeep = '0;
        mLane = 0;
        wordsPushed = 0;
        notReadyWaits = 0;
        waitCycles(2);
        ap_areset = 1'b0;
        checkOutput("reset word_count", 64'(word_count), 64'd0);
        checkOutput("reset s_axis_tready", 64'(s_axis_tready), 64'd1);
        checkOutput("reset m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkOutput("reset m_axis_tkeep", 64'(m_axis_tkeep), 64'd0);
`ifdef VADD_FLOAT_PACKER_ZERO_PAD_EN
        checkOutput("reset m_axis_tdata zero", 64'(|m_axis_tdata), 64'd0);
`endif
    endtask

    // Monitor: checks held-word stability and pops the scoreboard on every output handshake.
    initial begin
        bit            hold = 1'b0;
        logic [M-1:0]  pData = '0;
        logic [MK-1:0] pKeep = '0;
        logic          pLast = 1'b0;
        logic [M-1:0]  mask;
        word_t         e;
        forever begin
            @(negedge clk);
            if (ap_areset) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                testsRun++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pData || m_axis_tkeep !== pKeep || m_axis_tlast !== pLast) begin
                    testsFailed++;
                    $display("[TB] FAIL held word stability: valid %0b keep 0x%0h last %0b, required valid 1 keep 0x%0h last %0b",
                             m_axis_tvalid, m_axis_tkeep, m_axis_tlast, pKeep, pLast);
                end
            end
            hold  = m_axis_tvalid && !m_axis_tready;
            pData = m_axis_tdata;
            pKeep = m_axis_tkeep;
            pLast = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                rxData.push_back(m_axis_tdata);
                rxKeep.push_back(m_axis_tkeep);
                rxLast.push_back(m_axis_tlast);
                testsRun++;
                if (expQ.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL unexpected word: keep 0x%0h with empty scoreboard", m_axis_tkeep);
                end else begin
                    e = expQ.pop_front();
                    for (int b = 0; b < MK; b++) mask[b*8 +: 8] = {8{e.keep[b]}};
`ifdef VADD_FLOAT_PACKER_ZERO_PAD_EN
                    mask = '1;
`endif
                    if (m_axis_tkeep !== e.keep || m_axis_tlast !== e.last || (m_axis_tdata & mask) !== (e.data & mask)) begin
                        testsFailed++;
                        $display("[TB] FAIL word compare: keep 0x%0h last %0b data 0x%0h, required keep 0x%0h last %0b data 0x%0h",
                                 m_axis_tkeep, m_axis_tlast, m_axis_tdata & mask, e.keep, e.last, e.data & mask);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [M-1:0] w;
        int           budget;
        waitCycles(1);

        // Full word of 16 beats at full rate.
        resetDut();
        readyMode = 1;
        for (int k = 0; k < 16; k++) applyStimulus(32'h3F800000 + 32'(k), 4'hF, k == 15, 0);
        checkOutput("t1 valid one cycle after beat 16", 64'(m_axis_tvalid), 64'd1);
        checkOutput("t1 s_axis_tready never low", 64'(notReadyWaits), 64'd0);
        waitCycles(3);
        checkOutput("t1 word count", 64'(rxData.size()), 64'd1);
        if (rxData.size() > 0) begin
            w = rxData[0];
            for (int k = 0; k < 16; k++) checkOutput($sformatf("t1 lane %0d", k), 64'(w[k*S +: S]), 64'h3F800000 + 64'(k));
            checkOutput("t1 keep", 64'(rxKeep[0]), 64'hFFFF_FFFF_FFFF_FFFF);
            checkOutput("t1 last", 64'(rxLast[0]), 64'd1);
        end
        checkOutput("t1 word_count", 64'(word_count), 64'd1);

        // 37 beats: 16 + 16 + 5 lanes.
        resetDut();
        for (int i = 0; i < 37; i++) applyStimulus(32'h1000 + 32'(i), 4'hF, i == 36, 0);
        waitCycles(3);
        checkOutput("t2 words", 64'(rxData.size()), 64'd3);
        if (rxData.size() == 3) begin
            checkOutput("t2 keep0", 64'(rxKeep[0]), 64'hFFFF_FFFF_FFFF_FFFF);
            checkOutput("t2 keep1", 64'(rxKeep[1]), 64'hFFFF_FFFF_FFFF_FFFF);
            checkOutput("t2 keep2", 64'(rxKeep[2]), 64'h0000_0000_000F_FFFF);
            checkOutput("t2 lasts", 64'({rxLast[2], rxLast[1], rxLast[0]}), 64'b100);
        end
        checkOutput("t2 word_count", 64'(word_count), 64'd3);

        // Backpressure: 32 beats with m_axis_tready low.
        resetDut();
        readyMode = 0;
        for (int i = 0; i < 32; i++) applyStimulus(32'hA0000000 + 32'(i), 4'hF, 1'b0, 0);
        checkOutput("t3 tready low after beat 32", 64'(s_axis_tready), 64'd0);
        waitCycles(3);
        checkOutput("t3 tready still low", 64'(s_axis_tready), 64'd0);
        checkOutput("t3 word1 held valid", 64'(m_axis_tvalid), 64'd1);
        checkOutput("t3 word1 lane0", 64'(m_axis_tdata[31:0]), 64'hA0000000);
        checkOutput("t3 word_count held", 64'(word_count), 64'd0);
        readyMode = 1;
        waitCycles(1);
        checkOutput("t3 word2 valid next cycle", 64'(m_axis_tvalid), 64'd1);
        checkOutput("t3 word2 lane0", 64'(m_axis_tdata[31:0]), 64'hA0000010);
        checkOutput("t3 tready back high", 64'(s_axis_tready), 64'd1);
        checkOutput("t3 word_count after word1", 64'(word_count), 64'd1);
        waitCycles(2);
        checkOutput("t3 word_count after word2", 64'(word_count), 64'd2);
        checkOutput("t3 words", 64'(rxData.size()), 64'd2);

        // tlast on lane 0, then a keep-zero beat still occupying a lane.
        resetDut();
        applyStimulus(32'h40490FDB, 4'hF, 1'b1, 0);
        applyStimulus(32'h11111111, 4'h0, 1'b0, 0);
        applyStimulus(32'h22222222, 4'hF, 1'b1, 0);
        waitCycles(3);
        checkOutput("t4 words", 64'(rxData.size()), 64'd2);
        if (rxData.size() == 2) begin
            w = rxData[0];
            checkOutput("t4 lane0 data", 64'(w[31:0]), 64'h40490FDB);
            checkOutput("t4 lane0 keep", 64'(rxKeep[0]), 64'h000F);
`ifdef VADD_FLOAT_PACKER_ZERO_PAD_EN
            checkOutput("t4 upper bits zero", 64'(|w[M-1:32]), 64'd0);
`endif
            w = rxData[1];
            checkOutput("t4 keep-zero lane", 64'(rxKeep[1]), 64'h00F0);
            checkOutput("t4 lane1 data", 64'(w[63:32]), 64'h22222222);
        end

        // Reset mid-word discards the partial accumulation.
        resetDut();
        for (int i = 0; i < 7; i++) applyStimulus(32'hDEAD0000 + 32'(i), 4'hF, 1'b0, 0);
        resetDut();
        for (int i = 0; i < 16; i++) applyStimulus(32'h55550000 + 32'(i), 4'hF, 1'b0, 0);
        waitCycles(3);
        checkOutput("t5 words", 64'(rxData.size()), 64'd1);
        if (rxData.size() > 0) begin
            w = rxData[0];
            checkOutput("t5 lane0", 64'(w[31:0]), 64'h55550000);
            checkOutput("t5 lane15", 64'(w[15*S +: S]), 64'h5555000F);
            checkOutput("t5 keep", 64'(rxKeep[0]), 64'hFFFF_FFFF_FFFF_FFFF);
        end
        checkOutput("t5 word_count", 64'(word_count), 64'd1);

        // Random valid gaps and ready toggling.
        resetDut();
        readyMode = 2;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom, (i % 7 == 3) ? 4'($urandom_range(0, 15)) : 4'hF,
                          (i % 53) == 52, $urandom_range(0, 1));
        end
        readyMode = 1;
        budget = 0;
        while (expQ.size() != 0 && budget < 200) begin
            waitCycles(1);
            budget++;
        end
        waitCycles(2);
        checkOutput("t6 scoreboard drained", 64'(expQ.size()), 64'd0);
        checkOutput("t6 word_count", 64'(word_count), 64'(wordsPushed));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
